// File: rtl/ring_osc_sched.sv
// Ring-oscillator bank scheduler: sweeps masked channels one at a time, counting divided-clock edges over a gate window.
// Build option: define RING_OSC_SCHED_OVF_EN to add the result_ovf saturation flag.
module ring_osc_sched #(
  parameter int NUM_OSC       = 4,
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  localparam int CH_W         = $clog2(NUM_OSC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_OSC-1:0] chan_mask,
  input  logic [GATE_W-1:0]  gate_cycles,
  output logic [NUM_OSC-1:0] osc_en,
  input  logic [NUM_OSC-1:0] osc_div,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CH_W-1:0]    result_chan,
  output logic [CNT_W-1:0]   result_count,
`ifdef RING_OSC_SCHED_OVF_EN
  output logic               result_ovf,
  output logic               done
`else
  output logic               done
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

  state_t             state_q, state_d;
  logic [NUM_OSC-1:0] mask_q;
  logic [NUM_OSC-1:0] rem_mask;
  logic [NUM_OSC-1:0] ch_onehot;
  logic [GATE_W-1:0]  gate_q;
  logic [CH_W-1:0]    ch_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [TMR_W-1:0]   gate_last;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         sync_q;
  logic               hist_q;
  logic               rise;
  logic               done_q;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_OSC-1:0] m);
    lowest_set = '0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  assign ch_onehot = NUM_OSC'(1) << ch_q;
  assign rem_mask  = mask_q & ~ch_onehot;
  assign gate_last = TMR_W'(gate_q) - TMR_W'(1);
  assign rise      = sync_q[1] & ~hist_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    osc_en       = '0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start && (|chan_mask)) state_d = SETTLE;
      end
      SETTLE: begin
        osc_en = ch_onehot;
        if (tmr_q == SETTLE_LAST) state_d = (gate_q == '0) ? REPORT : MEASURE;
      end
      MEASURE: begin
        osc_en = ch_onehot;
        if (tmr_q == gate_last) state_d = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        if (result_ready) state_d = (|rem_mask) ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= '0;
      gate_q <= '0;
      ch_q   <= '0;
      tmr_q  <= '0;
      cnt_q  <= '0;
      sync_q <= '0;
      hist_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // Mux first, then two synchronizer flops and the edge history; history tracks every cycle,
      // so it already holds the settled level when the gate opens.
      sync_q <= {sync_q[0], osc_div[ch_q]};
      hist_q <= sync_q[1];
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (|chan_mask) begin
              mask_q <= chan_mask;
              gate_q <= gate_cycles;
              ch_q   <= lowest_set(chan_mask);
              tmr_q  <= '0;
              cnt_q  <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (tmr_q == SETTLE_LAST) tmr_q <= '0;
          else                      tmr_q <= tmr_q + TMR_W'(1);
        end
        MEASURE: begin
          if (tmr_q == gate_last) tmr_q <= '0;
          else                    tmr_q <= tmr_q + TMR_W'(1);
          if (rise && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
        REPORT: begin
          if (result_ready) begin
            if (|rem_mask) begin
              mask_q <= rem_mask;
              ch_q   <= lowest_set(rem_mask);
              cnt_q  <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign result_chan  = ch_q;
  assign result_count = cnt_q;
  assign done         = done_q;

`ifdef RING_OSC_SCHED_OVF_EN
  assign result_ovf = (state_q == REPORT) && (&cnt_q);
`endif

endmodule

// File: tb/tb_ring_osc_sched.sv
// Self-checking bench for ring_osc_sched: table of sweeps plus back-pressure, restart, reset and saturation sequences.
module tb_ring_osc_sched;
  localparam int NUM_OSC = 4;
  localparam int SETTLE  = 4;

  typedef struct packed {
    logic [3:0]      mask;
    logic [15:0]     gate;
    logic [3:0][7:0] half;
    logic [3:0]      lvl;
    int              n_res;
    int              busy_cyc;
  } vec_t;

  typedef struct {
    logic [1:0] chan;
    int         cnt;
    int         tol;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, s_start, result_ready;
  logic [3:0]  chan_mask;
  logic [15:0] gate_cycles;
  logic [3:0]  osc_div;
  logic [3:0]  osc_en, s_osc_en;
  logic        busy, result_valid, done;
  logic        s_busy, s_result_valid, s_done;
  logic [1:0]  result_chan, s_result_chan;
  logic [15:0] result_count;
  logic [3:0]  s_result_count;
`ifdef RING_OSC_SCHED_OVF_EN
  logic        result_ovf, s_result_ovf;
`endif

  int total = 0;
  int bad = 0;
  int popped = 0;
  int viol = 0;
  exp_t sb[$];
  logic [3:0]      cur_mask = '0;
  logic [3:0][7:0] osc_half = '0;
  logic [3:0]      osc_lvl = '0;

  always #5 clk = ~clk;

  ring_osc_sched dut (
    .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask), .gate_cycles(gate_cycles),
    .osc_en(osc_en), .osc_div(osc_div), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result_chan(result_chan), .result_count(result_count),
`ifdef RING_OSC_SCHED_OVF_EN
    .result_ovf(result_ovf),
`endif
    .done(done)
  );

  ring_osc_sched #(.CNT_W(4)) s_dut (
    .clk(clk), .rst(rst), .start(s_start), .chan_mask(chan_mask), .gate_cycles(gate_cycles),
    .osc_en(s_osc_en), .osc_div(osc_div), .busy(s_busy), .result_valid(s_result_valid),
    .result_ready(result_ready), .result_chan(s_result_chan), .result_count(s_result_count),
`ifdef RING_OSC_SCHED_OVF_EN
    .result_ovf(s_result_ovf),
`endif
    .done(s_done)
  );

  task automatic check(input string name, input longint act, input longint exp, input longint tol);
    total++;
    if (act < exp - tol || act > exp + tol) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-running square waves: toggle every osc_half[i] clk cycles, or hold osc_lvl[i] when half is 0.
  initial begin
    int ph[NUM_OSC];
    osc_div = '0;
    foreach (ph[i]) ph[i] = 0;
    forever begin
      @(posedge clk);
      #3;
      for (int i = 0; i < NUM_OSC; i++) begin
        if (osc_half[i] == 8'd0) begin
          osc_div[i] = osc_lvl[i];
        end else begin
          ph[i]++;
          if (ph[i] >= int'(osc_half[i])) begin
            ph[i] = 0;
            osc_div[i] = ~osc_div[i];
          end
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every handshake and tracks enable invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (((osc_en & (osc_en - 4'd1)) != 4'd0) || ((osc_en & ~cur_mask) != 4'd0) ||
            (result_valid && osc_en != 4'd0))
          viol++;
        if (result_valid && result_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got chan %0d count %0d, want no result", result_chan, result_count);
          end else begin
            e = sb.pop_front();
            check("result_chan", result_chan, e.chan, 0);
            check("result_count", result_count, e.cnt, e.tol);
`ifdef RING_OSC_SCHED_OVF_EN
            check("result_ovf", result_ovf, 0, 0);
`endif
            popped++;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [3:0] m, input logic [15:0] g);
    exp_t e;
    chan_mask   = m;
    gate_cycles = g;
    for (int i = 0; i < NUM_OSC; i++) begin
      if (m[i]) begin
        e.chan = 2'(i);
        if (g == 16'd0 || osc_half[i] == 8'd0) begin
          e.cnt = 0;
          e.tol = 0;
        end else begin
          e.cnt = int'(g) / (2 * int'(osc_half[i]));
          e.tol = 1;
        end
        sb.push_back(e);
      end
    end
    cur_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    if (got) begin
      check("done_busy_low", busy, 0, 0);
      @(negedge clk);
      check("done_width", done, 0, 0);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int bc;
    bit got;
    int p0;
    osc_half     = v.half;
    osc_lvl      = v.lvl;
    result_ready = 1'b1;
    viol         = 0;
    p0           = popped;
    tick();
    do_start(v.mask, v.gate);
    wait_done(bc, got);
    check({tag, "_done_seen"}, got, 1, 0);
    check({tag, "_busy_cycles"}, bc, v.busy_cyc, 0);
    check({tag, "_results"}, popped - p0, v.n_res, 0);
    check({tag, "_sb_empty"}, sb.size(), 0, 0);
    check({tag, "_osc_en_rules"}, viol, 0, 0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    bit got;
    int bc, hv;
    logic [1:0] c0;
    logic [15:0] n0;

    start = 1'b0; s_start = 1'b0; result_ready = 1'b1;
    chan_mask = '0; gate_cycles = '0;
    repeat (3) tick();
    check("rst_osc_en", osc_en, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_valid", result_valid, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_count", result_count, 0, 0);
    check("rst_chan", result_chan, 0, 0);
    rst = 1'b0;
    tick();

    // busy_cyc = channels * (SETTLE + gate + 1)
    vecs[0] = '{mask: 4'b1010, gate: 16'd100, half: {8'd4, 8'd0, 8'd8, 8'd0}, lvl: 4'b0000, n_res: 2, busy_cyc: 210};
    vecs[1] = '{mask: 4'b0000, gate: 16'd100, half: {8'd4, 8'd0, 8'd8, 8'd0}, lvl: 4'b0000, n_res: 0, busy_cyc: 0};
    vecs[2] = '{mask: 4'b1111, gate: 16'd0,   half: {8'd3, 8'd3, 8'd3, 8'd3}, lvl: 4'b0000, n_res: 4, busy_cyc: 20};
    vecs[3] = '{mask: 4'b0101, gate: 16'd20,  half: {8'd0, 8'd3, 8'd0, 8'd5}, lvl: 4'b0000, n_res: 2, busy_cyc: 50};
    vecs[4] = '{mask: 4'b0001, gate: 16'd10,  half: {8'd0, 8'd0, 8'd0, 8'd0}, lvl: 4'b0001, n_res: 1, busy_cyc: 15};
    vecs[5] = '{mask: 4'b1000, gate: 16'd1,   half: {8'd3, 8'd0, 8'd0, 8'd0}, lvl: 4'b0000, n_res: 1, busy_cyc: 6};
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: hold the first result for 50 cycles with ready low.
    v = '{mask: 4'b0110, gate: 16'd10, half: {8'd0, 8'd3, 8'd4, 8'd0}, lvl: 4'b0000, n_res: 2, busy_cyc: 0};
    osc_half = v.half; osc_lvl = v.lvl; viol = 0;
    result_ready = 1'b0;
    tick();
    do_start(v.mask, v.gate);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (result_valid) got = 1'b1;
    end
    check("bp_valid_seen", got, 1, 0);
    c0 = result_chan;
    n0 = result_count;
    hv = 0;
    repeat (50) begin
      @(negedge clk);
      if (result_chan != c0 || result_count != n0 || !result_valid || osc_en != 4'd0 || !busy) hv++;
    end
    check("bp_hold_stable", hv, 0, 0);
    check("bp_first_chan", c0, 1, 0);
    tick();
    result_ready = 1'b1;
    tick();
    check("bp_next_osc_en", osc_en, 4'b0100, 0);
    check("bp_next_valid_low", result_valid, 0, 0);
    wait_done(bc, got);
    check("bp_done_seen", got, 1, 0);
    check("bp_sb_empty", sb.size(), 0, 0);
    check("bp_osc_en_rules", viol, 0, 0);

    // start re-pulsed mid-sweep with a different mask: ignored.
    osc_half = {8'd0, 8'd0, 8'd5, 8'd5}; osc_lvl = '0; viol = 0;
    tick();
    do_start(4'b0011, 16'd30);
    repeat (10) tick();
    chan_mask = 4'b1100;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(bc, got);
    check("restart_done_seen", got, 1, 0);
    check("restart_busy_cycles", bc, 59, 0);
    check("restart_sb_empty", sb.size(), 0, 0);
    check("restart_osc_en_rules", viol, 0, 0);

    // Reset during MEASURE, then a fresh sweep.
    tick();
    do_start(4'b0001, 16'd50);
    repeat (SETTLE + 5) tick();
    check("pre_rst_osc_en", osc_en, 4'b0001, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_osc_en", osc_en, 0, 0);
    check("mid_rst_busy", busy, 0, 0);
    check("mid_rst_valid", result_valid, 0, 0);
    rst = 1'b0;
    sb.delete();
    v = '{mask: 4'b0001, gate: 16'd20, half: {8'd0, 8'd0, 8'd5, 8'd5}, lvl: 4'b0000, n_res: 1, busy_cyc: 25};
    run_vec("post_rst", v);

    // Saturation on the narrow-counter instance.
    osc_half = {8'd0, 8'd0, 8'd0, 8'd3}; osc_lvl = '0;
    chan_mask = 4'b0001; gate_cycles = 16'd200;
    tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (s_result_valid) got = 1'b1;
    end
    check("sat_valid_seen", got, 1, 0);
    check("sat_count", s_result_count, 15, 0);
    check("sat_chan", s_result_chan, 0, 0);
`ifdef RING_OSC_SCHED_OVF_EN
    check("sat_ovf", s_result_ovf, 1, 0);
`endif
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (s_done) got = 1'b1;
    end
    check("sat_done_seen", got, 1, 0);
    check("sat_busy_low", s_busy, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
